// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN_3_3 requantization path.
package cnn_pkg;

  localparam int ACC_W     = 64;
  localparam int OUT_W     = 8;
  localparam int SH_W      = 8;
  localparam int MAX_SHIFT = 63;

  localparam int SAT_MAX   = 127;
  localparam int SAT_MIN   = -128;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/requant_core.sv
// Combinational round-half-up arithmetic shift and saturation of one accumulator.
// The sum is formed one bit wider than the accumulator so that adding the
// rounding constant to a near-maximum positive value cannot wrap negative.
module requant_core #(
  parameter int ACC_W = cnn_pkg::ACC_W,
  parameter int OUT_W = cnn_pkg::OUT_W,
  parameter int SH_W  = cnn_pkg::SH_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [SH_W-1:0]  shift_i,
  output logic signed [OUT_W-1:0] res_o
);
  import cnn_pkg::*;

  localparam int SW  = clog2(MAX_SHIFT + 1);
  localparam int RIW = clog2(ACC_W + 1);
  localparam logic signed [ACC_W:0] HI = SAT_MAX;
  localparam logic signed [ACC_W:0] LO = SAT_MIN;

  logic        [SW-1:0]  sh;
  logic        [RIW-1:0] rnd_idx;
  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  // Clamp the shift, add half an LSB of the result, shift, then saturate.
  always_comb begin
    sh      = (shift_i > SH_W'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : shift_i[SW-1:0];
    ext     = {acc_i[ACC_W-1], acc_i};
    rnd     = '0;
    rnd_idx = RIW'(sh) - RIW'(1);
    if (sh != '0) begin
      rnd[rnd_idx] = 1'b1;
    end
    sum = ext + rnd;
    r   = sum >>> sh;
    if (r > HI) begin
      res_o = OUT_W'(SAT_MAX);
    end else if (r < LO) begin
      res_o = OUT_W'(SAT_MIN);
    end else begin
      res_o = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/requant_scheduler.sv
// Shares one requantization stage between NREQ requesters: per-requester shift
// table, round-robin arbiter, and a two-entry capture/compute pipeline with a
// valid/ready output toward the activation buffer.
module requant_scheduler #(
  parameter int NREQ  = 4,
  parameter int ACC_W = cnn_pkg::ACC_W,
  parameter int OUT_W = cnn_pkg::OUT_W,
  parameter int SH_W  = cnn_pkg::SH_W
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [NREQ*ACC_W-1:0]                req_acc,
  output logic [NREQ-1:0]                      req_ready,
  input  logic                                 cfg_we,
  input  logic [cnn_pkg::clog2(NREQ)-1:0]      cfg_idx,
  input  logic [SH_W-1:0]                      cfg_shift,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [OUT_W-1:0]              out_data,
  output logic [cnn_pkg::clog2(NREQ)-1:0]      out_src,
  output logic [31:0]                          out_cnt
);
  import cnn_pkg::*;

  localparam int IW = clog2(NREQ);

  logic [SH_W-1:0]         tbl_q [NREQ];
  logic [IW-1:0]           ptr_q;

  logic                    s1_v_q;
  logic signed [ACC_W-1:0] s1_acc_q;
  logic [SH_W-1:0]         s1_sh_q;
  logic [IW-1:0]           s1_src_q;

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic [IW-1:0]           out_src_q;
  logic [31:0]             out_cnt_q;

  logic                    s2_adv;
  logic                    s1_free;
  logic                    gnt_v;
  logic                    grant;
  logic [IW-1:0]           gnt_idx;
  logic [IW-1:0]           cand;
  logic signed [OUT_W-1:0] core_res;

  // Stage 1 may move on when stage 2 is empty or its result is being taken.
  assign s2_adv  = s1_v_q & (!out_valid_q | out_ready);
  assign s1_free = !s1_v_q | !out_valid_q | out_ready;
  assign grant   = rstn & s1_free & gnt_v;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = ptr_q + IW'(i);
      if (!gnt_v && req_valid[cand]) begin
        gnt_v   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot accept toward the winning requester.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Shift table; a grant in the same cycle reads the pre-write entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl_q[cfg_idx] <= cfg_shift;
    end
  end

  requant_core #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_core (
    .acc_i   (s1_acc_q),
    .shift_i (s1_sh_q),
    .res_o   (core_res)
  );

  // Capture stage, compute/output stage, RR pointer and delivery counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q       <= IW'(NREQ - 1);
      s1_v_q      <= 1'b0;
      s1_acc_q    <= '0;
      s1_sh_q     <= '0;
      s1_src_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      if (grant) begin
        s1_v_q   <= 1'b1;
        s1_acc_q <= req_acc[gnt_idx*ACC_W +: ACC_W];
        s1_sh_q  <= tbl_q[gnt_idx];
        s1_src_q <= gnt_idx;
        ptr_q    <= gnt_idx;
      end else if (s2_adv) begin
        s1_v_q <= 1'b0;
      end

      if (s2_adv) begin
        out_valid_q <= 1'b1;
        out_data_q  <= core_res;
        out_src_q   <= s1_src_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (out_valid_q && out_ready) begin
        out_cnt_q <= out_cnt_q + 32'd1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_requant_scheduler.sv
// Directed bench for requant_scheduler: single-request vector table plus
// hand-written sequences for arbitration, stall/drain, config collision and reset.
module tb_requant_scheduler;
  import cnn_pkg::*;

  localparam int NREQ = 4;
  localparam int IW   = 2;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ACC_W-1:0]   req_acc;
  logic [NREQ-1:0]         req_ready;
  logic                    cfg_we;
  logic [IW-1:0]           cfg_idx;
  logic [SH_W-1:0]         cfg_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [IW-1:0]           out_src;
  logic [31:0]             out_cnt;

  requant_scheduler #(
    .NREQ  (NREQ),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_acc   (req_acc),
    .req_ready (req_ready),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [IW-1:0]   idx;
    logic [SH_W-1:0] sh;
    logic [63:0]     acc;
    logic [63:0]     exp;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic signed [OUT_W-1:0] v);
    return 64'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    cfg_we    = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic set_acc_all();
    for (int i = 0; i < NREQ; i++) begin
      req_acc[i*ACC_W +: ACC_W] = 64'(10 + i);
    end
  endtask

  initial begin
    int got_src [4];
    int got_dat [4];
    int ng;

    // idx, shift, acc, expected result (sign-extended to 64 bits)
    vt[0] = '{2'd0, 8'd3,   64'd200,                   64'd25};
    vt[1] = '{2'd1, 8'd2,   -64'sd100,                 -64'sd25};
    vt[2] = '{2'd2, 8'd0,   64'd5,                     64'd5};
    vt[3] = '{2'd3, 8'd200, -64'sd1,                   64'd0};
    vt[4] = '{2'd3, 8'd4,   64'h1000,                  64'd127};
    vt[5] = '{2'd3, 8'd4,   -64'sh1000,                -64'sd128};
    vt[6] = '{2'd2, 8'd0,   64'h7FFF_FFFF_FFFF_FFFF,   64'd127};
    vt[7] = '{2'd0, 8'd63,  64'h7FFF_FFFF_FFFF_FFFF,   64'd1};
    vt[8] = '{2'd1, 8'd1,   -64'sd3,                   -64'sd1};

    rstn      = 1'b0;
    req_valid = 4'hF;
    req_acc   = '0;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_shift = '0;
    out_ready = 1'b1;
    step();
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  sx(out_data),   64'd0);
    chk("rst_src",   64'(out_src),   64'd0);
    chk("rst_cnt",   64'(out_cnt),   64'd0);
    req_valid = '0;
    rstn = 1'b1;
    step();

    // Single-request vectors, out_ready held high.
    for (int k = 0; k < 9; k++) begin
      cfg_we    = 1'b1;
      cfg_idx   = vt[k].idx;
      cfg_shift = vt[k].sh;
      step();
      cfg_we    = 1'b0;
      req_acc   = '0;
      req_acc[vt[k].idx*ACC_W +: ACC_W] = vt[k].acc;
      req_valid = 4'b0001 << vt[k].idx;
      #1;
      chk("vec_ready", 64'(req_ready), 64'(req_valid));
      step();
      req_valid = '0;
      #1;
      chk("vec_early_valid", 64'(out_valid), 64'd0);
      step();
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk("vec_data",  sx(out_data),   vt[k].exp);
      chk("vec_src",   64'(out_src),   64'(vt[k].idx));
      step();
      chk("vec_cnt",   64'(out_cnt),   64'(k + 1));
      chk("vec_idle",  64'(out_valid), 64'd0);
    end

    // Config write colliding with a grant to the same entry.
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_shift = 8'd3;
    step();
    req_acc   = '0;
    req_acc[0 +: ACC_W] = 64'd200;
    req_valid = 4'b0001;
    cfg_shift = 8'd1;
    #1;
    chk("coll_ready", 64'(req_ready), 64'd1);
    step();
    cfg_we = 1'b0;
    req_valid = '0;
    step();
    chk("coll_old_shift", sx(out_data), 64'd25);
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    chk("coll_new_shift", sx(out_data), 64'd100);
    step();

    // Round-robin with all requesters valid, shifts 0 after reset.
    do_reset();
    set_acc_all();
    out_ready = 1'b1;
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 2) begin
        chk("rr_valid", 64'(out_valid), 64'd1);
        chk("rr_src",   64'(out_src),   64'((c - 2) % 4));
        chk("rr_data",  sx(out_data),   64'(10 + (c - 2) % 4));
      end
      step();
    end
    req_valid = '0;
    step(); step(); step();

    // Stall: two grants fill the pipe, then nothing more is accepted.
    do_reset();
    set_acc_all();
    out_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("stall_g0", 64'(req_ready), 64'b0001);
    step();
    chk("stall_g1", 64'(req_ready), 64'b0010);
    step();
    for (int c = 0; c < 4; c++) begin
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data",  sx(out_data),   64'd10);
      chk("stall_src",   64'(out_src),   64'd0);
      step();
    end
    out_ready = 1'b1;
    req_valid = '0;
    ng = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid && ng < 4) begin
        got_src[ng] = int'(out_src);
        got_dat[ng] = int'(out_data);
        ng++;
      end
      step();
    end
    chk("drain_count", 64'(ng), 64'd2);
    if (ng >= 2) begin
      chk("drain_src0", 64'(got_src[0]), 64'd0);
      chk("drain_dat0", 64'(got_dat[0]), 64'd10);
      chk("drain_src1", 64'(got_src[1]), 64'd1);
      chk("drain_dat1", 64'(got_dat[1]), 64'd11);
    end
    chk("drain_cnt", 64'(out_cnt), 64'd2);

    // Reset with both stages full discards everything.
    out_ready = 1'b0;
    req_valid = 4'hF;
    step();
    step();
    chk("full_valid", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'd0);
    step();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_cnt",   64'(out_cnt),   64'd0);
    rstn = 1'b1;
    #1;
    chk("midrst_first_grant", 64'(req_ready), 64'b0001);
    step();
    out_ready = 1'b1;
    req_valid = '0;
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'd1);
    chk("midrst_out_src",   64'(out_src),   64'd0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
